// File: rtl/gauss_pkg.sv
// rtl/gauss_pkg.sv - shared widths, default sigma-1.6 kernel and pixel helpers for gauss11_conv
package gauss_pkg;

  localparam int PIX_W   = 8;
  localparam int COEF_W  = 8;
  localparam int VSUM_W  = 16;
  localparam int ACC_W   = 25;
  localparam int LAT     = 5;
  localparam int CNT_W   = 21;
  localparam int TAPS    = 11;
  localparam int CTR     = 5;
  localparam int NCOEF   = 6;
  localparam int ROW_W   = TAPS * PIX_W;
  localparam int FRAC_W  = 16;
  localparam int ROUND   = 32768;
  localparam int PIX_MAX = 255;

  localparam logic [COEF_W-1:0] K0_DEF = 8'd64;
  localparam logic [COEF_W-1:0] K1_DEF = 8'd53;
  localparam logic [COEF_W-1:0] K2_DEF = 8'd29;
  localparam logic [COEF_W-1:0] K3_DEF = 8'd11;
  localparam logic [COEF_W-1:0] K4_DEF = 8'd3;
  localparam logic [COEF_W-1:0] K5_DEF = 8'd0;

  function automatic logic [PIX_W-1:0] pix_at(input logic [ROW_W-1:0] row, input int unsigned j);
    return row[j*PIX_W +: PIX_W];
  endfunction

  function automatic int unsigned tap_dist(input int unsigned i);
    return (i >= CTR) ? i - CTR : CTR - i;
  endfunction

endpackage

// File: rtl/gauss11_conv_if.sv
// rtl/gauss11_conv_if.sv - window-in / pixel-out bundle between window generator, blur stage and consumer
interface gauss11_conv_if;
  import gauss_pkg::*;

  logic             in_valid;
  logic [ROW_W-1:0] in_row1, in_row2, in_row3, in_row4, in_row5, in_row6;
  logic [ROW_W-1:0] in_row7, in_row8, in_row9, in_row10, in_row11;
  logic             in_complete;
  logic [PIX_W-1:0] dout;
  logic             dout_valid;
  logic             frame_done;
  logic [CNT_W-1:0] out_cnt;

  modport master (
    output in_valid, in_row1, in_row2, in_row3, in_row4, in_row5, in_row6,
           in_row7, in_row8, in_row9, in_row10, in_row11, in_complete,
    input  dout, dout_valid, frame_done, out_cnt
  );

  modport slave (
    input  in_valid, in_row1, in_row2, in_row3, in_row4, in_row5, in_row6,
           in_row7, in_row8, in_row9, in_row10, in_row11, in_complete,
    output dout, dout_valid, frame_done, out_cnt
  );

endinterface

// File: rtl/gauss_tap11.sv
// rtl/gauss_tap11.sv - symmetric 11-tap weighted sum: registered products, then registered saturating add
module gauss_tap11 import gauss_pkg::*; #(
  parameter int                        IN_W  = 8,
  parameter int                        OUT_W = 16,
  parameter logic [NCOEF*COEF_W-1:0]   COEFS = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  tap_in [TAPS],
  output logic [OUT_W-1:0] sum_out
);

  localparam int PROD_W = IN_W + COEF_W;
  localparam int FULL_W = PROD_W + 4;

  logic [PROD_W-1:0] prod_d [TAPS];
  logic [PROD_W-1:0] prod_q [TAPS];
  logic [OUT_W-1:0]  sum_d, sum_q;
  logic [FULL_W-1:0] full;

  always_comb begin
    full = '0;
    for (int i = 0; i < TAPS; i++) begin
      prod_d[i] = PROD_W'(tap_in[i]) * PROD_W'(COEFS[tap_dist(i)*COEF_W +: COEF_W]);
      full      = full + FULL_W'(prod_q[i]);
    end
    // Overweight kernels clamp instead of wrapping
    sum_d = (|full[FULL_W-1:OUT_W]) ? '1 : full[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) prod_q[i] <= '0;
      sum_q <= '0;
    end else begin
      for (int i = 0; i < TAPS; i++) prod_q[i] <= prod_d[i];
      sum_q <= sum_d;
    end
  end

  assign sum_out = sum_q;

endmodule

// File: rtl/gauss11_conv.sv
// rtl/gauss11_conv.sv - separable 11x11 Gaussian blur, one window in and one pixel out per cycle, 5-cycle latency
module gauss11_conv import gauss_pkg::*; #(
  parameter logic [COEF_W-1:0] K0 = K0_DEF,
  parameter logic [COEF_W-1:0] K1 = K1_DEF,
  parameter logic [COEF_W-1:0] K2 = K2_DEF,
  parameter logic [COEF_W-1:0] K3 = K3_DEF,
  parameter logic [COEF_W-1:0] K4 = K4_DEF,
  parameter logic [COEF_W-1:0] K5 = K5_DEF
) (
  input  logic          clk,
  input  logic          rst,
  gauss11_conv_if.slave bus
);

  localparam logic [NCOEF*COEF_W-1:0] COEFS = {K5, K4, K3, K2, K1, K0};

  logic [ROW_W-1:0]  rows [TAPS];
  logic [VSUM_W-1:0] vsum [TAPS];
  logic [ACC_W-1:0]  acc;
  logic [ACC_W:0]    rnd_hi;

  logic [LAT-1:0]    vld_d, vld_q;
  logic [LAT-1:0]    cmp_d, cmp_q;
  logic [PIX_W-1:0]  dout_d, dout_q;
  logic [CNT_W-1:0]  out_cnt_d, out_cnt_q;

  always_comb begin
    rows[0]  = bus.in_row1;
    rows[1]  = bus.in_row2;
    rows[2]  = bus.in_row3;
    rows[3]  = bus.in_row4;
    rows[4]  = bus.in_row5;
    rows[5]  = bus.in_row6;
    rows[6]  = bus.in_row7;
    rows[7]  = bus.in_row8;
    rows[8]  = bus.in_row9;
    rows[9]  = bus.in_row10;
    rows[10] = bus.in_row11;
  end

  // Vertical pass: one tap per column, stages S1 (products) and S2 (sums)
  for (genvar j = 0; j < TAPS; j++) begin : g_col
    logic [PIX_W-1:0] col [TAPS];

    always_comb begin
      for (int r = 0; r < TAPS; r++) col[r] = pix_at(rows[r], j);
    end

    gauss_tap11 #(.IN_W(PIX_W), .OUT_W(VSUM_W), .COEFS(COEFS)) u_vtap (
      .clk     (clk),
      .rst     (rst),
      .tap_in  (col),
      .sum_out (vsum[j])
    );
  end

  // Horizontal pass over the column sums: stages S3 and S4
  gauss_tap11 #(.IN_W(VSUM_W), .OUT_W(ACC_W), .COEFS(COEFS)) u_htap (
    .clk     (clk),
    .rst     (rst),
    .tap_in  (vsum),
    .sum_out (acc)
  );

  always_comb begin
    vld_d  = {vld_q[LAT-2:0], bus.in_valid};
    cmp_d  = {cmp_q[LAT-2:0], bus.in_complete};
    rnd_hi = ({1'b0, acc} + (ACC_W+1)'(ROUND)) >> FRAC_W;
    dout_d = dout_q;
    if (vld_q[LAT-2]) begin
      dout_d = (rnd_hi > (ACC_W+1)'(PIX_MAX)) ? '1 : rnd_hi[PIX_W-1:0];
    end
    out_cnt_d = out_cnt_q;
    if (cmp_q[LAT-2]) begin
      out_cnt_d = CNT_W'(vld_q[LAT-2]);
    end else if (vld_q[LAT-2]) begin
      out_cnt_d = out_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q     <= '0;
      cmp_q     <= '0;
      dout_q    <= '0;
      out_cnt_q <= '0;
    end else begin
      vld_q     <= vld_d;
      cmp_q     <= cmp_d;
      dout_q    <= dout_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = vld_q[LAT-1];
  assign bus.frame_done = cmp_q[LAT-1];
  assign bus.out_cnt    = out_cnt_q;

endmodule

// File: tb/tb_gauss11_conv.sv
// tb/tb_gauss11_conv.sv - directed bench for gauss11_conv with hand-computed blur results
module tb_gauss11_conv;
  import gauss_pkg::*;

  logic clk;
  logic rst;

  gauss11_conv_if bus ();
  gauss11_conv_if bus_sat ();

  gauss11_conv u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  gauss11_conv #(
    .K0(8'd255), .K1(8'd255), .K2(8'd255), .K3(8'd255), .K4(8'd255), .K5(8'd255)
  ) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_sat)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [ROW_W-1:0] win [TAPS];
  bit ev [LAT];
  int ed [LAT];
  bit ec [LAT];
  int hold_d;
  int cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_const(input logic [PIX_W-1:0] p);
    for (int r = 0; r < TAPS; r++) win[r] = {TAPS{p}};
  endtask

  task automatic set_imp(input int r, input int j, input logic [PIX_W-1:0] p);
    for (int k = 0; k < TAPS; k++) win[k] = '0;
    win[r][j*PIX_W +: PIX_W] = p;
  endtask

  task automatic drive_win();
    bus.in_row1  = win[0];
    bus.in_row2  = win[1];
    bus.in_row3  = win[2];
    bus.in_row4  = win[3];
    bus.in_row5  = win[4];
    bus.in_row6  = win[5];
    bus.in_row7  = win[6];
    bus.in_row8  = win[7];
    bus.in_row9  = win[8];
    bus.in_row10 = win[9];
    bus.in_row11 = win[10];
  endtask

  task automatic drive_sat(input logic [PIX_W-1:0] p);
    bus_sat.in_row1  = {TAPS{p}};
    bus_sat.in_row2  = {TAPS{p}};
    bus_sat.in_row3  = {TAPS{p}};
    bus_sat.in_row4  = {TAPS{p}};
    bus_sat.in_row5  = {TAPS{p}};
    bus_sat.in_row6  = {TAPS{p}};
    bus_sat.in_row7  = {TAPS{p}};
    bus_sat.in_row8  = {TAPS{p}};
    bus_sat.in_row9  = {TAPS{p}};
    bus_sat.in_row10 = {TAPS{p}};
    bus_sat.in_row11 = {TAPS{p}};
  endtask

  // One clock: present a window, then check what emerges LAT edges after it was presented
  task automatic cycle(input bit v, input bit c, input int expd);
    bus.in_valid    = v;
    bus.in_complete = c;
    drive_win();
    @(posedge clk);
    #1;
    for (int i = LAT - 1; i > 0; i--) begin
      ev[i] = ev[i-1];
      ed[i] = ed[i-1];
      ec[i] = ec[i-1];
    end
    ev[0] = v;
    ed[0] = expd;
    ec[0] = c;
    chk("dout_valid", bus.dout_valid, ev[LAT-1]);
    chk("frame_done", bus.frame_done, ec[LAT-1]);
    if (ev[LAT-1]) hold_d = ed[LAT-1];
    chk("dout", bus.dout, hold_d);
    if (ec[LAT-1]) cnt = ev[LAT-1] ? 1 : 0;
    else if (ev[LAT-1]) cnt = (cnt + 1) % (1 << CNT_W);
    chk("out_cnt", bus.out_cnt, cnt);
  endtask

  task automatic do_reset();
    rst                 = 1'b0;
    bus.in_valid        = 1'b0;
    bus.in_complete     = 1'b0;
    bus_sat.in_valid    = 1'b0;
    bus_sat.in_complete = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < LAT; i++) begin
      ev[i] = 1'b0;
      ed[i] = 0;
      ec[i] = 1'b0;
    end
    hold_d = 0;
    cnt    = 0;
    chk("rst_dout", bus.dout, 0);
    chk("rst_dout_valid", bus.dout_valid, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_out_cnt", bus.out_cnt, 0);
    chk("rst_sat_valid", bus_sat.dout_valid, 0);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    set_const(8'd0);
    drive_win();
    drive_sat(8'd0);
    do_reset();

    // Flat field of 100: every output 100, continuous from the fifth clock
    set_const(8'd100);
    repeat (20) cycle(1'b1, 1'b0, 100);
    set_const(8'd0);
    repeat (LAT) cycle(1'b0, 1'b0, 0);
    chk("cnt_after_20", bus.out_cnt, 20);

    // Single 255 impulses, back to back
    set_imp(5, 5, 8'd255); cycle(1'b1, 1'b0, 16);
    set_imp(5, 4, 8'd255); cycle(1'b1, 1'b0, 13);
    set_imp(5, 6, 8'd255); cycle(1'b1, 1'b0, 13);
    set_imp(0, 0, 8'd255); cycle(1'b1, 1'b0, 0);
    set_imp(1, 5, 8'd255); cycle(1'b1, 1'b0, 1);
    set_imp(5, 3, 8'd255); cycle(1'b1, 1'b0, 7);
    set_const(8'd0);
    repeat (LAT) cycle(1'b0, 1'b0, 0);

    // Valid pattern 1,0,1,1,0 with bubbles carrying junk windows
    set_const(8'd10); cycle(1'b1, 1'b0, 10);
    set_const(8'd99); cycle(1'b0, 1'b0, 0);
    set_const(8'd20); cycle(1'b1, 1'b0, 20);
    set_const(8'd30); cycle(1'b1, 1'b0, 30);
    set_const(8'd99); cycle(1'b0, 1'b0, 0);
    repeat (LAT) cycle(1'b0, 1'b0, 0);

    // Frame end coincident with the last window, then a bare end pulse, then a new frame
    set_const(8'd50);
    cycle(1'b1, 1'b0, 50);
    cycle(1'b1, 1'b0, 50);
    cycle(1'b1, 1'b1, 50);
    repeat (LAT) cycle(1'b0, 1'b0, 0);
    cycle(1'b0, 1'b1, 0);
    repeat (LAT) cycle(1'b0, 1'b0, 0);
    chk("cnt_cleared", bus.out_cnt, 0);
    set_const(8'd60);
    cycle(1'b1, 1'b0, 60);
    repeat (LAT) cycle(1'b0, 1'b0, 0);
    chk("cnt_restart", bus.out_cnt, 1);

    // Reset with windows in flight
    set_const(8'd70);
    repeat (3) cycle(1'b1, 1'b0, 70);
    repeat (2) cycle(1'b0, 1'b0, 0);
    do_reset();
    repeat (LAT + 1) cycle(1'b0, 1'b0, 0);
    set_const(8'd80);
    cycle(1'b1, 1'b0, 80);
    repeat (LAT - 1) cycle(1'b0, 1'b0, 0);
    chk("post_rst_valid", bus.dout_valid, 1);
    chk("post_rst_dout", bus.dout, 80);
    cycle(1'b0, 1'b0, 0);

    // Overweight kernel: all-255 window clamps, all-1 window gives 120
    bus_sat.in_valid = 1'b1;
    drive_sat(8'd255);
    cycle(1'b0, 1'b0, 0);
    drive_sat(8'd1);
    cycle(1'b0, 1'b0, 0);
    bus_sat.in_valid = 1'b0;
    repeat (LAT - 2) cycle(1'b0, 1'b0, 0);
    chk("sat_valid", bus_sat.dout_valid, 1);
    chk("sat_dout", bus_sat.dout, 255);
    cycle(1'b0, 1'b0, 0);
    chk("sat_valid2", bus_sat.dout_valid, 1);
    chk("sat_dout_ones", bus_sat.dout, 120);
    cycle(1'b0, 1'b0, 0);
    chk("sat_valid3", bus_sat.dout_valid, 0);
    chk("sat_cnt", bus_sat.out_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
